// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: merges ALU and load results into one RF write port
// through a small circular FIFO and answers hazard queries against pending writes.
module rf_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ALUV,
   input  logic [4:0]  ALUA,
   input  logic [31:0] ALUD,
   output logic        ALURDY,
   input  logic        MEMV,
   input  logic [4:0]  MEMA,
   input  logic [31:0] MEMD,
   output logic        MEMRDY,
   output logic [1:0]  RFWE,
   output logic [4:0]  RFWA,
   output logic [31:0] RFWD,
   input  logic [4:0]  QA,
   output logic        QHIT,
   output logic [31:0] QD,
   output logic [2:0]  PEND
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [4:0]  addr_q [DEPTH];
   logic [31:0] data_q [DEPTH];

   ptr_t head_q, head_d;
   ptr_t tail_q, tail_d;
   ptr_t alu_idx;
   cnt_t count_q, count_d;
   cnt_t free_w;
   logic mem_push, alu_push, pop;

   // Readiness looks only at occupancy, never at the pop happening this cycle.
   assign free_w = cnt_t'(DEPTH) - count_q;
   assign MEMRDY = (free_w >= cnt_t'(1));
   assign ALURDY = (free_w >= cnt_t'(2)) | ((free_w == cnt_t'(1)) & ~MEMV);

   // Writes to r0 complete the handshake but are never stored.
   assign mem_push = MEMV & MEMRDY & (MEMA != 5'd0);
   assign alu_push = ALUV & ALURDY & (ALUA != 5'd0);
   assign pop      = (count_q != '0);

   always_comb begin
      alu_idx = tail_q + PW'(mem_push);
      tail_d  = tail_q + PW'(mem_push) + PW'(alu_push);
      head_d  = head_q + PW'(pop);
      count_d = count_q + cnt_t'(mem_push) + cnt_t'(alu_push) - cnt_t'(pop);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // MEM lands first (older), ALU in the following slot.
   always_ff @(posedge CLK) begin
      if (mem_push) begin
         addr_q[tail_q] <= MEMA;
         data_q[tail_q] <= MEMD;
      end
      if (alu_push) begin
         addr_q[alu_idx] <= ALUA;
         data_q[alu_idx] <= ALUD;
      end
   end

   assign RFWE = {1'b0, pop};
   assign RFWA = pop ? addr_q[head_q] : 5'd0;
   assign RFWD = pop ? data_q[head_q] : 32'd0;
   assign PEND = 3'(count_q);

   // Scan oldest to youngest so the last match seen is the newest write.
   always_comb begin
      ptr_t q_idx;
      QHIT  = 1'b0;
      QD    = 32'd0;
      q_idx = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         q_idx = head_q + PW'(i);
         if ((cnt_t'(i) < count_q) && (QA != 5'd0) && (addr_q[q_idx] == QA)) begin
            QHIT = 1'b1;
            QD   = data_q[q_idx];
         end
      end
   end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        aluv, memv;
  logic [4:0]  alua, mema, qa;
  logic [31:0] alud, memd;
  logic        alurdy, memrdy, qhit;
  logic [1:0]  rfwe;
  logic [4:0]  rfwa;
  logic [31:0] rfwd, qd;
  logic [2:0]  pend;

  always #5 clk = ~clk;

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst),
    .ALUV(aluv), .ALUA(alua), .ALUD(alud), .ALURDY(alurdy),
    .MEMV(memv), .MEMA(mema), .MEMD(memd), .MEMRDY(memrdy),
    .RFWE(rfwe), .RFWA(rfwa), .RFWD(rfwd),
    .QA(qa), .QHIT(qhit), .QD(qd), .PEND(pend)
  );

  // Each entry is {addr[4:0], data[31:0]}; index 0 is the oldest.
  logic [36:0] model_q[$];
  logic [36:0] rf_log[$];
  int n_checks = 0;
  int n_pass   = 0;
  int max_pend = 0;
  logic acc_m, acc_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: drive inputs after the falling edge, compare against the model,
  // then advance the model to what the next rising edge must produce.
  task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic [4:0] q, output logic am, output logic aal);
    int free_n;
    logic e_mrdy, e_ardy, e_hit;
    logic [31:0] e_qd, e_wd;
    logic [4:0] e_wa;
    @(negedge clk);
    memv = mv; mema = ma; memd = md;
    aluv = av; alua = aa; alud = ad;
    qa = q;
    #1;
    free_n = DEPTH - model_q.size();
    e_mrdy = (free_n >= 1);
    e_ardy = (free_n >= 2) || (free_n == 1 && !mv);
    e_hit = 1'b0;
    e_qd  = 32'd0;
    foreach (model_q[i]) begin
      if (q != 5'd0 && model_q[i][36:32] == q) begin
        e_hit = 1'b1;
        e_qd  = model_q[i][31:0];
      end
    end
    e_wa = (model_q.size() != 0) ? model_q[0][36:32] : 5'd0;
    e_wd = (model_q.size() != 0) ? model_q[0][31:0] : 32'd0;
    check("pend",   32'(pend),   32'(model_q.size()));
    check("rfwe",   32'(rfwe),   (model_q.size() != 0) ? 32'd1 : 32'd0);
    check("rfwa",   32'(rfwa),   32'(e_wa));
    check("rfwd",   rfwd,        e_wd);
    check("memrdy", 32'(memrdy), 32'(e_mrdy));
    check("alurdy", 32'(alurdy), 32'(e_ardy));
    check("qhit",   32'(qhit),   32'(e_hit));
    check("qd",     qd,          e_qd);
    if (int'(pend) > max_pend) max_pend = int'(pend);
    if (rfwe == 2'b01) rf_log.push_back({rfwa, rfwd});
    am  = mv && e_mrdy;
    aal = av && e_ardy;
    if (rst) model_q.delete();
    else begin
      if (model_q.size() != 0) void'(model_q.pop_front());
      if (am && ma != 5'd0) model_q.push_back({ma, md});
      if (aal && aa != 5'd0) model_q.push_back({aa, ad});
    end
  endtask

  task automatic idle(input logic [4:0] q);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q, acc_m, acc_a);
  endtask

  initial begin
    int nxt;
    rst = 1'b1;
    memv = 1'b0; mema = '0; memd = '0;
    aluv = 1'b0; alua = '0; alud = '0; qa = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_pend", 32'(pend), 32'd0);
    check("reset_rfwe", 32'(rfwe), 32'd0);
    check("reset_rfwa", 32'(rfwa), 32'd0);
    check("reset_rfwd", rfwd, 32'd0);
    check("reset_qhit", 32'(qhit), 32'd0);
    check("reset_qd",   qd, 32'd0);
    rst = 1'b0;

    idle(5'd0);
    check("post_reset_memrdy", 32'(memrdy), 32'd1);
    check("post_reset_alurdy", 32'(alurdy), 32'd1);

    // Single ALU write
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, acc_m, acc_a);
    check("single_alurdy", 32'(alurdy), 32'd1);
    idle(5'd5);
    check("single_rfwe", 32'(rfwe), 32'd1);
    check("single_rfwa", 32'(rfwa), 32'd5);
    check("single_rfwd", rfwd, 32'hDEADBEEF);
    check("single_pend", 32'(pend), 32'd1);
    check("single_qhit", 32'(qhit), 32'd1);
    idle(5'd0);
    check("single_drained", 32'(pend), 32'd0);

    // Dual push: MEM is older than ALU
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd0, acc_m, acc_a);
    idle(5'd0);
    check("dual_first_rfwa", 32'(rfwa), 32'd3);
    check("dual_first_rfwd", rfwd, 32'h11);
    check("dual_pend", 32'(pend), 32'd2);
    idle(5'd0);
    check("dual_second_rfwa", 32'(rfwa), 32'd4);
    check("dual_second_rfwd", rfwd, 32'h22);
    idle(5'd0);
    check("dual_drained", 32'(pend), 32'd0);

    // r0 write is accepted and dropped
    step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0, acc_m, acc_a);
    check("r0_memrdy", 32'(memrdy), 32'd1);
    idle(5'd0);
    check("r0_pend", 32'(pend), 32'd0);
    check("r0_rfwe", 32'(rfwe), 32'd0);

    // Hazard query: newest r7 wins; same-cycle incoming writes are invisible
    step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, acc_m, acc_a);
    check("hazard_incoming_qhit", 32'(qhit), 32'd0);
    idle(5'd7);
    check("hazard_qhit", 32'(qhit), 32'd1);
    check("hazard_qd", qd, 32'h2);
    idle(5'd0);
    check("hazard_q0_qhit", 32'(qhit), 32'd0);
    check("hazard_q0_qd", qd, 32'd0);
    idle(5'd0);

    // Back-to-back writes r1..r6 using both ports; pointers wrap
    rf_log.delete();
    max_pend = 0;
    nxt = 1;
    for (int c = 0; c < 20 && nxt <= 6; c++) begin
      step(1'b1, 5'(nxt), 32'h100 + 32'(nxt),
           (nxt + 1 <= 6), 5'(nxt + 1), 32'h100 + 32'(nxt + 1), 5'd0, acc_m, acc_a);
      if (c == 2) begin
        check("fill_pend3", 32'(pend), 32'd3);
        check("fill_alurdy_low", 32'(alurdy), 32'd0);
        check("fill_memrdy_high", 32'(memrdy), 32'd1);
      end
      if (acc_m && acc_a) nxt += 2;
      else if (acc_m) nxt += 1;
    end
    repeat (5) idle(5'd0);
    check("fill_count", 32'(rf_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < rf_log.size(); i++)
      check("fill_order", 32'(rf_log[i][36:32]), 32'(i + 1));
    for (int i = 0; i < 6 && i < rf_log.size(); i++)
      check("fill_data", rf_log[i][31:0], 32'h101 + 32'(i));
    check("fill_max_pend_le_depth", 32'(max_pend <= DEPTH), 32'd1);

    // Asynchronous reset with three pending writes
    step(1'b1, 5'd8, 32'hA, 1'b1, 5'd9, 32'hB, 5'd0, acc_m, acc_a);
    step(1'b1, 5'd10, 32'hC, 1'b1, 5'd11, 32'hD, 5'd0, acc_m, acc_a);
    @(posedge clk);
    #2;
    check("prereset_pend", 32'(pend), 32'd3);
    memv = 1'b0; aluv = 1'b0; qa = 5'd10;
    rst = 1'b1;
    #1;
    check("async_reset_pend", 32'(pend), 32'd0);
    check("async_reset_rfwe", 32'(rfwe), 32'd0);
    check("async_reset_rfwa", 32'(rfwa), 32'd0);
    check("async_reset_qhit", 32'(qhit), 32'd0);
    model_q.delete();
    rf_log.delete();
    step(1'b1, 5'd12, 32'hE, 1'b1, 5'd13, 32'hF, 5'd12, acc_m, acc_a);
    step(1'b1, 5'd14, 32'hE, 1'b1, 5'd15, 32'hF, 5'd14, acc_m, acc_a);
    memv = 1'b0; aluv = 1'b0;
    rst = 1'b0;
    idle(5'd0);
    check("after_reset_memrdy", 32'(memrdy), 32'd1);
    check("after_reset_alurdy", 32'(alurdy), 32'd1);
    check("no_write_during_reset", 32'(rf_log.size()), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), acc_m, acc_a);
    end
    repeat (6) idle(5'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_writeback_queue.md
RF_WRITEBACK_QUEUE -- requirements
Module: rf_writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of pending-write entries; it SHALL be a power of two, minimum 2.
REQ-002 Port CLK, input, 1, is the system clock; all state SHALL update on its rising edge.
REQ-003 Port RST, input, 1, is the reset: asynchronous, active-high.
REQ-004 Port ALUV, input, 1, is the ALU result valid.
REQ-005 Port ALUA, input, 5, is the ALU destination register.
REQ-006 Port ALUD, input, 32, is the ALU result data.
REQ-007 Port ALURDY, output, 1, indicates the queue accepts the ALU write this cycle.
REQ-008 Port MEMV / MEMA / MEMD, inputs, 1 / 5 / 32, are the load-result valid, destination and data.
REQ-009 Port MEMRDY, output, 1, indicates the queue accepts the MEM write this cycle.
REQ-010 Port RFWE, output, 2, is the register-file write enable: 2'b01 = write, 2'b00 = idle.
REQ-011 Port RFWA, output, 5, is the register-file write address.
REQ-012 Port RFWD, output, 32, is the register-file write data.
REQ-013 Port QA, input, 5, is the hazard-query register address.
REQ-014 Port QHIT, output, 1, indicates a pending write to QA exists.
REQ-015 Port QD, output, 32, is the data of the newest pending write to QA.
REQ-016 Port PEND, output, 3, is the current entry count (0..DEPTH).

Function
REQ-017 The block SHALL be a circular FIFO of {addr[4:0], data[31:0]} with head/tail pointers and a count; it SHALL be the sole driver of the RF write port.
REQ-018 A transfer SHALL occur on a rising edge when xV and xRDY are both 1; xRDY SHALL NOT depend on the same-cycle pop.
REQ-019 free = DEPTH - PEND; MEMRDY = (free >= 1); ALURDY = (free >= 2) | ((free == 1) & ~MEMV).
REQ-020 When both transfer in the same cycle, MEM SHALL be enqueued first (older) and ALU second, giving two entries in one edge.
REQ-021 A transfer with address 0 SHALL be accepted (handshake completes) but SHALL NOT be stored.
REQ-022 RFWE SHALL be 2'b01 whenever PEND > 0, else 2'b00.
REQ-023 RFWA/RFWD SHALL present the head entry combinationally; the head SHALL pop on every edge where RFWE == 2'b01.
REQ-024 RFWA and RFWD SHALL be 0 when PEND == 0.
REQ-025 Latency: a write accepted at edge N into an empty queue SHALL be driven during cycle N+1 and committed by the RF at edge N+1.
REQ-026 Push and pop on the same edge SHALL both take effect; PEND SHALL update by (pushes - pop).
REQ-027 When full, PEND = DEPTH; both RDY outputs SHALL be 0, and a pop SHALL still occur.
REQ-028 Pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-029 QHIT SHALL be 1 iff QA != 0 and any valid entry has addr == QA.
REQ-030 QD SHALL return the youngest matching entry's data; it SHALL be 0 when QHIT == 0.
REQ-031 The query SHALL reflect current queue contents only, not same-cycle incoming writes.

Reset
REQ-032 While RST = 1, asynchronously: PEND = 0, pointers = 0, RFWE = 2'b00, RFWA = 0, RFWD = 0, QHIT = 0, QD = 0.
REQ-033 Entry storage SHALL NOT require reset.
REQ-034 Reset asserted mid-operation SHALL discard all pending writes; no RF write SHALL occur while RST = 1.
REQ-035 After RST deasserts, MEMRDY = ALURDY = 1.

Verification
REQ-036 Single write: ALUV=1, ALUA=5, ALUD=0xDEADBEEF for one cycle -> next cycle RFWE=01, RFWA=5, RFWD=0xDEADBEEF; PEND returns to 0 after one further edge.
REQ-037 Dual push: MEMA=3/0x11 and ALUA=4/0x22 in the same cycle -> RF writes r3=0x11 then r4=0x22 on consecutive cycles.
REQ-038 Fill: 6 back-to-back writes to r1..r6 with the RF side idle-free -> PEND never exceeds 4, RDY deasserts when full, all 6 are written in order, and pointers wrap.
REQ-039 r0 drop: MEMA=0, MEMD=0x55 -> MEMRDY=1, PEND stays 0, RFWE stays 00.
REQ-040 Hazard: pending r7=0x1 then r7=0x2, QA=7 -> QHIT=1, QD=0x2; QA=0 -> QHIT=0, QD=0.
REQ-041 Reset with PEND=3 -> PEND=0, RFWE=00 immediately without waiting for a clock edge; no further RF writes occur.
